// File: rtl/inst_cache_if.sv
// Fetch-side and memory-side bus of the instruction cache.
//   slave  : the cache itself (takes fetch requests, issues memory reads)
//   master : the environment (IF stage, pipeline controller, instruction memory)
// Signals:
//   inst_ren/inst_addr/flush     fetch request, byte address, invalidate-all pulse
//   inst_data/inst_ready         same-cycle hit data and hit flag
//   inst_stall                   IF stage must hold inst_addr
//   mem_req/mem_addr             word read request and word-aligned address
//   mem_ack/mem_data             memory returns the word for mem_addr
//   miss_count                   number of refills started
interface inst_cache_if;
  logic        inst_ren;
  logic [31:0] inst_addr;
  logic [31:0] inst_data;
  logic        inst_ready;
  logic        inst_stall;
  logic        flush;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_data;
  logic [31:0] miss_count;

  modport slave (
    input  inst_ren, inst_addr, flush, mem_ack, mem_data,
    output inst_data, inst_ready, inst_stall, mem_req, mem_addr, miss_count
  );

  modport master (
    output inst_ren, inst_addr, flush, mem_ack, mem_data,
    input  inst_data, inst_ready, inst_stall, mem_req, mem_addr, miss_count
  );
endinterface

// File: rtl/inst_cache.sv
// Direct-mapped, read-only instruction cache between the IF stage and a
// word-wide instruction memory. Hits return data in the same cycle; a miss
// refills the whole line word by word over a req/ack handshake while
// inst_stall holds the IF stage.
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    inst_cache_if.slave (fetch side + memory side + miss counter)
// Parameters:
//   LINE_WORDS  words per line (power of 2, >= 2)
//   LINES       number of lines (power of 2, >= 2)
module inst_cache #(
  parameter int LINE_WORDS = 4,
  parameter int LINES      = 16
) (
  input logic         clk,
  input logic         rst_n,
  inst_cache_if.slave bus
);

  localparam int OFF   = $clog2(LINE_WORDS);
  localparam int IDX   = $clog2(LINES);
  localparam int TAG_W = 30 - OFF - IDX;

  typedef enum logic {IDLE, REFILL} state_t;

  state_t               state;
  logic [OFF-1:0]       cnt;
  logic [IDX-1:0]       idx_l;
  logic [TAG_W-1:0]     tag_l;
  logic                 flush_pending;
  logic [31:0]          miss_count;
  logic [LINES-1:0]     valid;

  logic [31:0]          data_arr [LINES*LINE_WORDS];
  logic [TAG_W-1:0]     tag_arr  [LINES];

  logic [OFF-1:0]       off;
  logic [IDX-1:0]       idx;
  logic [TAG_W-1:0]     tag;
  logic                 hit;
  logic                 last_word;
  logic                 unused_addr_bits;

  assign off = bus.inst_addr[OFF+1:2];
  assign idx = bus.inst_addr[OFF+IDX+1:OFF+2];
  assign tag = bus.inst_addr[31:OFF+IDX+2];
  assign unused_addr_bits = ^bus.inst_addr[1:0];

  // Gated by rst_n so the IF stage sees neither a hit nor a stall while reset is held.
  assign hit = rst_n & bus.inst_ren & valid[idx] & (tag_arr[idx] == tag) & (state == IDLE);

  assign bus.inst_ready = hit;
  assign bus.inst_data  = hit ? data_arr[{idx, off}] : '0;
  assign bus.inst_stall = rst_n & ((bus.inst_ren & ~hit) | (state != IDLE));
  assign bus.mem_req    = (state == REFILL);
  assign bus.mem_addr   = (state == REFILL) ? {tag_l, idx_l, cnt, 2'b00} : '0;
  assign bus.miss_count = miss_count;

  assign last_word = (cnt == OFF'(LINE_WORDS - 1));

  // NOTE: the tag and data arrays carry no reset; a line is only ever read
  // after its valid bit is set, and valid bits are what reset clears.
  always_ff @(posedge clk) begin
    if (rst_n && state == REFILL && bus.mem_ack) begin
      data_arr[{idx_l, cnt}] <= bus.mem_data;
      if (last_word) tag_arr[idx_l] <= tag_l;
    end
  end

  // NOTE: all state here uses non-blocking assignments; where two assignments
  // to the same bit occur in one edge (flush vs. fill), the later one wins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      valid         <= '0;
      cnt           <= '0;
      flush_pending <= 1'b0;
      miss_count    <= '0;
      idx_l         <= '0;
      tag_l         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.flush) valid <= '0;
          // Miss: the line is invalidated up front so a partial refill can never hit.
          if (bus.inst_ren && !hit) begin
            state      <= REFILL;
            tag_l      <= tag;
            idx_l      <= idx;
            valid[idx] <= 1'b0;
            cnt        <= '0;
            miss_count <= miss_count + 32'd1;
          end
        end
        REFILL: begin
          if (bus.flush) flush_pending <= 1'b1;
          if (bus.mem_ack) begin
            cnt <= cnt + OFF'(1);
            if (last_word) begin
              state         <= IDLE;
              flush_pending <= 1'b0;
              // A flush seen during the refill also discards the line just filled.
              if (flush_pending || bus.flush) valid <= '0;
              else                            valid[idx_l] <= 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_cache.sv
module tb_inst_cache;

  localparam int LW = 4;
  localparam int NL = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  inst_cache_if bus ();

  inst_cache #(.LINE_WORDS(LW), .LINES(NL)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Stimulus knobs, applied at the next falling edge.
  bit          rst   = 1'b0;
  bit          ren   = 1'b0;
  logic [31:0] addr  = '0;
  bit          fl    = 1'b0;
  int          lat   = 0;
  bit          stray = 1'b0;
  int          wait_c = 0;
  int          stall_seen = 0;
  bit          last_hit = 1'b0;

  // Reference model: which memory lines the cache holds, plus refill progress.
  bit          m_valid [NL];
  int unsigned m_tag   [NL];
  bit          m_busy = 1'b0;
  bit          m_pend = 1'b0;
  int unsigned m_base = 0;
  int unsigned m_done = 0;
  int unsigned m_miss = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h1000 + a;
  endfunction

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic clear_model_valid();
    foreach (m_valid[i]) m_valid[i] = 1'b0;
  endtask

  // One clock: drive inputs and the memory responder at negedge, compare
  // all outputs against the model, then advance the model across the edge.
  task automatic cycle();
    int unsigned li, lt, bi;
    bit          h;
    @(negedge clk);
    rst_n         = rst;
    bus.inst_ren  = ren;
    bus.inst_addr = addr;
    bus.flush     = fl;
    bus.mem_ack   = 1'b0;
    if (stray) begin
      bus.mem_ack = 1'b1;
    end else if (bus.mem_req === 1'b1) begin
      if (wait_c >= lat) begin
        bus.mem_ack = 1'b1;
        wait_c      = 0;
      end else begin
        wait_c++;
      end
    end else begin
      wait_c = 0;
    end
    bus.mem_data = mem_word(bus.mem_addr);
    #1;

    li = (addr / (4 * LW)) % NL;
    lt = addr / (4 * LW * NL);
    h  = rst && ren && !m_busy && m_valid[li] && (m_tag[li] == lt);

    check("inst_ready", {31'b0, bus.inst_ready}, {31'b0, h});
    check("inst_data", bus.inst_data, h ? mem_word(addr & ~32'h3) : 32'h0);
    check("inst_stall", {31'b0, bus.inst_stall}, {31'b0, rst && ((ren && !h) || m_busy)});
    check("mem_req", {31'b0, bus.mem_req}, {31'b0, m_busy});
    check("mem_addr", bus.mem_addr, m_busy ? m_base + 4 * m_done : 32'h0);
    check("miss_count", bus.miss_count, m_miss);
    if (bus.inst_stall === 1'b1) stall_seen++;
    last_hit = h;

    if (!rst) begin
      m_busy = 1'b0;
      m_pend = 1'b0;
      m_done = 0;
      m_miss = 0;
      clear_model_valid();
    end else if (!m_busy) begin
      if (fl) clear_model_valid();
      if (ren && !h) begin
        m_busy      = 1'b1;
        m_base      = addr & ~32'(4 * LW - 1);
        m_done      = 0;
        m_valid[li] = 1'b0;
        m_miss++;
      end
    end else begin
      if (fl) m_pend = 1'b1;
      if (bus.mem_ack) begin
        m_done++;
        if (m_done == LW) begin
          m_busy = 1'b0;
          bi     = (m_base / (4 * LW)) % NL;
          if (m_pend) begin
            clear_model_valid();
          end else begin
            m_valid[bi] = 1'b1;
            m_tag[bi]   = m_base / (4 * LW * NL);
          end
          m_pend = 1'b0;
        end
      end
    end
  endtask

  // Keep fetching one address until the model says it hit (bounded).
  task automatic fetch(input logic [31:0] a);
    int n;
    ren  = 1'b1;
    addr = a;
    n    = 0;
    last_hit = 1'b0;
    while (!last_hit && n < 200) begin
      cycle();
      n++;
    end
    check("fetch_completes", {31'b0, last_hit}, 32'd1);
  endtask

  initial begin
    bus.inst_ren  = 1'b0;
    bus.inst_addr = '0;
    bus.flush     = 1'b0;
    bus.mem_ack   = 1'b0;
    bus.mem_data  = '0;
    foreach (m_valid[i]) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = 0;
    end

    // Reset
    rst = 1'b0;
    repeat (2) cycle();
    rst = 1'b1;

    // Cold miss: 5 stall cycles, then hit on 0x40
    lat = 0;
    stall_seen = 0;
    fetch(32'h40);
    check("cold_stall_cycles", 32'(stall_seen), 32'd5);
    check("cold_data", bus.inst_data, 32'h1040);
    check("cold_miss_count", bus.miss_count, 32'd1);

    // Hit streak
    for (int i = 1; i < 4; i++) begin
      addr = 32'h40 + 32'(4 * i);
      cycle();
    end
    check("streak_miss_count", bus.miss_count, 32'd1);

    // Conflict with slow memory, then re-miss on 0x40
    lat = 2;
    fetch(32'h440);
    for (int i = 1; i < 4; i++) begin
      addr = 32'h440 + 32'(4 * i);
      cycle();
    end
    fetch(32'h40);
    check("conflict_miss_count", bus.miss_count, 32'd3);
    lat = 0;

    // Flush in the 2nd refill cycle of a miss at 0x80
    fetch(32'h440);
    ren  = 1'b1;
    addr = 32'h80;
    cycle();
    cycle();
    fl = 1'b1;
    cycle();
    fl = 1'b0;
    fetch(32'h80);
    fetch(32'h440);

    // Reset mid-refill after 2 acks, stray ack, full refill again
    ren  = 1'b1;
    addr = 32'hC0;
    cycle();
    cycle();
    cycle();
    rst = 1'b0;
    cycle();
    rst   = 1'b1;
    ren   = 1'b0;
    stray = 1'b1;
    cycle();
    check("reset_miss_count", bus.miss_count, 32'd0);
    stray = 1'b0;
    stall_seen = 0;
    fetch(32'hC0);
    check("rerefill_stall_cycles", 32'(stall_seen), 32'd5);
    check("rerefill_miss_count", bus.miss_count, 32'd1);

    // Redirect during refill
    lat  = 1;
    ren  = 1'b1;
    addr = 32'h100;
    cycle();
    cycle();
    cycle();
    fetch(32'h200);
    fetch(32'h100);
    fetch(32'h104);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      rst  = ($urandom_range(99) != 0);
      ren  = ($urandom_range(9) < 8);
      addr = (32'($urandom_range(3)) << 8) | ($urandom & 32'hFF);
      fl   = ($urandom_range(29) == 0);
      lat  = $urandom_range(2);
      cycle();
    end
    rst = 1'b1;
    fl  = 1'b0;
    lat = 0;
    fetch(32'h2F0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_cache.md
Name: inst_cache

Overview:
- Direct-mapped, read-only instruction cache between the IF stage and a word-wide instruction memory.
- Returns hits with zero latency. The IF stage keeps its existing same-cycle inst_data timing.
- On a miss, refills one whole line with a per-word req/ack handshake and holds the stall request high until the line is valid.
- The stall request feeds the pipeline controller, which deasserts if_en while stalled.

Parameters:
- LINE_WORDS, 4, words per line; power of 2, minimum 2.
- LINES, 16, number of lines; power of 2, minimum 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- inst_ren  in  1  fetch request from the IF stage.
- inst_addr  in  32  fetch byte address; bits [1:0] ignored.
- inst_data  out  32  fetched instruction; valid when inst_ready=1, otherwise 0.
- inst_ready  out  1  hit this cycle.
- inst_stall  out  1  IF stage must hold inst_addr.
- flush  in  1  invalidate all lines (single-cycle pulse).
- mem_req  out  1  word read request to instruction memory.
- mem_addr  out  32  word-aligned address of the requested word.
- mem_ack  in  1  memory returns mem_data for the current mem_addr this cycle.
- mem_data  in  32  returned word.
- miss_count  out  32  number of refills started; wraps at 2^32.

Behaviour:
- Address split:
  - word offset = inst_addr[OFF+1:2], with OFF = log2(LINE_WORDS).
  - index = next log2(LINES) bits.
  - tag = remaining upper bits.
- Storage: data array of LINES*LINE_WORDS words, a tag array, and a valid bit per line. The arrays are read combinationally.
- hit = inst_ren & valid[index] & (tag_arr[index] == tag) & (state == IDLE).
- inst_ready = hit.
- inst_data = hit ? word : 0.
- inst_stall = (inst_ren & ~hit) | (state != IDLE).
- States:
  - IDLE: on inst_ren & miss, go to REFILL at the next edge. On that edge:
    - latch line base {tag, index};
    - clear valid[index];
    - set word counter cnt = 0;
    - increment miss_count.
  - REFILL:
    - mem_req = 1.
    - mem_addr = {tag_l, index_l, cnt, 2'b00}.
    - On mem_ack: write mem_data into word cnt of the line, then cnt = cnt + 1.
    - On mem_ack with cnt == LINE_WORDS-1: write tag_arr, set valid, return to IDLE.
    - No ack: hold mem_req, mem_addr and cnt unchanged.
- mem_req stays high continuously across words. The address advances the cycle after each ack.
- mem_ack is ignored in IDLE.
- The first cycle back in IDLE re-evaluates hit against the current inst_addr. The refilled line hits in that cycle if the address is unchanged.
- inst_addr changing during REFILL (e.g. a redirect): the refill still completes for the latched line, and the new address is then looked up normally. A refill is never aborted except by reset.
- flush:
  - In IDLE: clears all valid bits at that edge. A hit in that cycle is still reported, using the pre-flush state.
  - In REFILL: sets flush_pending. At the final ack all valid bits are cleared, including the just-filled line, and flush_pending is cleared.
  - A flush in the same cycle as a miss in IDLE: the flush is applied, the refill starts, and the new line is valid at the end of the refill.
- Reset (rst_n = 0 at an edge), including mid-refill, after the edge:
  - state = IDLE, all valid = 0, cnt = 0, flush_pending = 0, miss_count = 0, mem_req = 0, mem_addr = 0.
  - Combinational outputs during reset cycles: inst_ready = 0, inst_data = 0, inst_stall = 0.
  - A late mem_ack after reset is ignored.
- Tag and data arrays are not reset.

Test Plan:
- Cold miss. After reset, inst_ren = 1, inst_addr = 0x0000_0040, memory acks every cycle returning 0x1000 + word address:
  - mem_addr sequence is 0x40, 0x44, 0x48, 0x4C.
  - inst_stall is high for 5 cycles.
  - The next cycle gives inst_ready = 1, inst_data = 0x1040.
  - miss_count = 1.
- Hit streak. After the line above, addresses 0x44, 0x48, 0x4C on consecutive cycles:
  - inst_ready = 1 each cycle, data 0x1044, 0x1048, 0x104C.
  - No mem_req.
  - miss_count stays 1.
- Conflict and slow memory. Access 0x440 (same index, different tag) with mem_ack delayed 2 cycles per word:
  - mem_addr is held until each ack.
  - Refill of 0x440 to 0x44C completes.
  - A subsequent access to 0x40 misses again, giving miss_count = 3.
- Flush during refill:
  - Pulse flush in the 2nd REFILL cycle of a miss at 0x80.
  - After the refill, 0x80 misses again, and the previously valid 0x440 line misses.
- Reset mid-refill:
  - Assert rst_n = 0 after 2 acks.
  - mem_req = 0 next cycle and miss_count = 0.
  - A stray mem_ack is ignored.
  - Re-access of the same address performs a full 4-word refill.
- Redirect during refill:
  - Change inst_addr from 0x100 to 0x200 mid-refill.
  - The 0x100 line completes, then 0x200 misses and refills.
  - Returning to 0x100 hits.
